// File: rtl/npc_pc_pkg.sv
// rtl/npc_pc_pkg.sv - shared types and constants for the NPC next-PC generator
// PC_GEN_MISALIGN_TRAP_EN enables redirecting misaligned adder targets to mtvec.
package npc_pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_t;

  localparam logic [1:0] KIND_ADD  = 2'b00;
  localparam logic [1:0] KIND_TRAP = 2'b01;
  localparam logic [1:0] KIND_RSVD = 2'b10;
  localparam logic [1:0] KIND_MRET = 2'b11;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP_EN = 1'b1;
`else
  localparam bit MISALIGN_TRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational redirect target select, adder, jalr mask, misalign check
// Misaligned adder targets divert to mtvec only when PC_GEN_MISALIGN_TRAP_EN is defined.
module pc_target_calc
  import npc_pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [1:0]       redir_kind,
  input  logic             redir_base_sel,
  input  logic             redir_jalr,
  input  logic [WIDTH-1:0] redir_src_pc,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] mepc,
  output logic [WIDTH-1:0] raw_target,
  output logic [WIDTH-1:0] target,
  output logic             mis_hit
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] add_tgt;
  logic             unaligned;

  assign base      = redir_base_sel ? rs1 : redir_src_pc;
  assign sum       = base + imm;
  assign add_tgt   = redir_jalr ? {sum[WIDTH-1:1], 1'b0} : sum;
  assign unaligned = (add_tgt % WIDTH'(STEP)) != '0;

  always_comb begin
    raw_target = add_tgt;
    mis_hit    = 1'b0;
    case (redir_kind)
      KIND_TRAP: raw_target = mtvec;
      KIND_MRET: raw_target = mepc;
      default:   mis_hit    = MISALIGN_TRAP_EN && unaligned;
    endcase
  end

  assign target = mis_hit ? mtvec : raw_target;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-PC generator: boot delay, fetch handshake, redirect with flush bubble
// Misalign reporting is live only when PC_GEN_MISALIGN_TRAP_EN is defined; otherwise it stays 0.
module pc_gen
  import npc_pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = 32'h8000_0000,
  parameter int               STEP        = 4,
  parameter int               BOOT_CYCLES = 2,
  parameter int               CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 pc_valid,
  input  logic                 ifu_ready,
  output logic [WIDTH-1:0]     pc,
  output logic                 flush,
  input  logic                 redir_valid,
  input  logic [1:0]           redir_kind,
  input  logic                 redir_base_sel,
  input  logic                 redir_jalr,
  input  logic [WIDTH-1:0]     redir_src_pc,
  input  logic [WIDTH-1:0]     rs1,
  input  logic [WIDTH-1:0]     imm,
  input  logic [WIDTH-1:0]     mtvec,
  input  logic [WIDTH-1:0]     mepc,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic                 misalign,
  output logic [WIDTH-1:0]     misalign_addr
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

  pc_state_t         state;
  logic [BOOT_W-1:0] boot_cnt;
  logic [WIDTH-1:0]  target;
  logic [WIDTH-1:0]  raw_target;
  logic              mis_hit;
  logic              fire;

  assign fire = pc_valid & ifu_ready;

  pc_target_calc #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_target (
    .redir_kind     (redir_kind),
    .redir_base_sel (redir_base_sel),
    .redir_jalr     (redir_jalr),
    .redir_src_pc   (redir_src_pc),
    .rs1            (rs1),
    .imm            (imm),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .raw_target     (raw_target),
    .target         (target),
    .mis_hit        (mis_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      boot_cnt      <= BOOT_W'(BOOT_CYCLES);
      pc            <= RESET_VEC;
      pc_valid      <= 1'b0;
      flush         <= 1'b0;
      fetch_cnt     <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      flush    <= 1'b0;
      misalign <= 1'b0;

      if (fire)
        fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);

      // Redirect beats the sequential step; a fetch fired alongside it is flushed by the IFU.
      if (redir_valid) begin
        pc <= target;
        if (mis_hit) begin
          misalign      <= 1'b1;
          misalign_addr <= raw_target;
        end
      end else if (fire) begin
        pc <= pc + WIDTH'(STEP);
      end

      case (state)
        BOOT: begin
          // Redirects during boot only preload pc; the boot delay still runs out.
          if (boot_cnt <= BOOT_W'(1)) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt - BOOT_W'(1);
          end
        end
        default: begin
          if (redir_valid) begin
            state    <= FLUSH;
            pc_valid <= 1'b0;
            flush    <= 1'b1;
          end else begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
